// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch stage.
// Issues one memory read at a time, holds the returned word until the
// consumer retires it, then advances the PC sequentially or to a redirect
// target. A request that is never acknowledged parks the unit in ERR.
// Optional feature macro: FETCH_ALIGN_CHECK_EN adds o_misalign and traps
// taken redirects to non-word-aligned targets.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_data,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  output logic        o_valid,
  input  logic        i_ready,
  input  logic        i_pcsrc,
  input  logic [31:0] i_nextpc,
  output logic        o_timeout,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic        o_misalign,
`endif
  output logic [31:0] o_icount
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  // Last wait-count value before the limit; reaching TIMEOUT ack-less
  // cycles is detected one count early so ERR is entered on that edge.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_valid;
  logic        r_req;
  logic        r_timeout;
  logic [31:0] r_icount;
  logic [7:0]  r_wait;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        r_misalign;
`endif

  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_next;
  logic        w_bad_redirect;

  // Next-PC selection, only consumed on a retiring HOLD cycle.
  always_comb begin
    w_pc_plus4     = r_pc + 32'd4;
    w_pc_next      = i_pcsrc ? i_nextpc : w_pc_plus4;
`ifdef FETCH_ALIGN_CHECK_EN
    w_bad_redirect = i_pcsrc && (i_nextpc[1:0] != 2'b00);
`else
    w_bad_redirect = 1'b0;
`endif
  end

  // Fetch FSM with all outputs registered.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_valid    <= 1'b0;
      r_req      <= 1'b0;
      r_timeout  <= 1'b0;
      r_icount   <= '0;
      r_wait     <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      r_misalign <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_REQ;
          r_req   <= 1'b1;
          r_wait  <= '0;
        end
        S_REQ: begin
          if (i_imem_ack) begin
            r_instr <= i_imem_data;
            r_valid <= 1'b1;
            r_req   <= 1'b0;
            r_state <= S_HOLD;
          end else if (r_wait == WAIT_LAST) begin
            r_req     <= 1'b0;
            r_timeout <= 1'b1;
            r_state   <= S_ERR;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        S_HOLD: begin
          if (i_ready) begin
            r_valid  <= 1'b0;
            r_icount <= r_icount + 32'd1;
            if (w_bad_redirect) begin
              // Trap without issuing: PC is left at the retired instruction.
`ifdef FETCH_ALIGN_CHECK_EN
              r_misalign <= 1'b1;
`endif
              r_state <= S_ERR;
            end else begin
              r_pc    <= w_pc_next;
              r_req   <= 1'b1;
              r_wait  <= '0;
              r_state <= S_REQ;
            end
          end
        end
        S_ERR: begin
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_imem_req  = r_req;
  assign o_imem_addr = r_pc;
  assign o_pc        = r_pc;
  assign o_pc_plus4  = w_pc_plus4;
  assign o_instr     = r_instr;
  assign o_valid     = r_valid;
  assign o_timeout   = r_timeout;
  assign o_icount    = r_icount;
`ifdef FETCH_ALIGN_CHECK_EN
  assign o_misalign  = r_misalign;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: transaction-level self-checking bench for fetch_unit.
// The reference is an expected PC / instruction / retire count updated per
// fetch-retire transaction; random waits, hold lengths, redirects and
// ignored-input noise exercise the handshake.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int unsigned TMO    = 16;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack;
  logic [31:0] i_imem_data;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic [31:0] o_pc_plus4;
  logic        o_valid;
  logic        i_ready;
  logic        i_pcsrc;
  logic [31:0] i_nextpc;
  logic        o_timeout;
  logic [31:0] o_icount;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        o_misalign;
`endif

  fetch_unit #(
    .RESET_PC (RST_PC),
    .TIMEOUT  (TMO)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .o_imem_req  (o_imem_req),
    .o_imem_addr (o_imem_addr),
    .i_imem_ack  (i_imem_ack),
    .i_imem_data (i_imem_data),
    .o_instr     (o_instr),
    .o_pc        (o_pc),
    .o_pc_plus4  (o_pc_plus4),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .i_pcsrc     (i_pcsrc),
    .i_nextpc    (i_nextpc),
    .o_timeout   (o_timeout),
`ifdef FETCH_ALIGN_CHECK_EN
    .o_misalign  (o_misalign),
`endif
    .o_icount    (o_icount)
  );

  always #5 i_clk = ~i_clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_instr;
  logic [31:0] exp_icount;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_req();
    int unsigned k = 0;
    while (!o_imem_req && k < 8) begin
      step();
      k++;
    end
    check("req_seen", 32'(o_imem_req), 32'd1);
  endtask

  // One fetch: `waits` ack-less REQ cycles, then an ack with `data`.
  task automatic fetch(input int unsigned waits, input logic [31:0] data);
    wait_req();
    check("imem_addr", o_imem_addr, exp_pc);
    for (int unsigned k = 0; k < waits; k++) begin
      i_ready = 1'($urandom_range(0, 1));
      step();
      check("req_held", 32'(o_imem_req), 32'd1);
      check("valid_low", 32'(o_valid), 32'd0);
    end
    i_ready     = 1'b0;
    i_imem_ack  = 1'b1;
    i_imem_data = data;
    step();
    i_imem_ack  = 1'b0;
    i_imem_data = $urandom;
    exp_instr   = data;
    check("valid_rise", 32'(o_valid), 32'd1);
    check("instr", o_instr, exp_instr);
    check("pc", o_pc, exp_pc);
    check("pc_plus4", o_pc_plus4, exp_pc + 32'd4);
    check("req_drop", 32'(o_imem_req), 32'd0);
  endtask

  // Stall in HOLD with noise on inputs that must be ignored.
  task automatic hold(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      i_pcsrc     = 1'($urandom_range(0, 1));
      i_nextpc    = $urandom;
      i_imem_ack  = 1'($urandom_range(0, 1));
      i_imem_data = $urandom;
      step();
      check("hold_instr", o_instr, exp_instr);
      check("hold_pc", o_pc, exp_pc);
      check("hold_valid", 32'(o_valid), 32'd1);
      check("hold_req", 32'(o_imem_req), 32'd0);
    end
    i_imem_ack = 1'b0;
  endtask

  task automatic retire(input logic pcsrc, input logic [31:0] npc);
    i_ready  = 1'b1;
    i_pcsrc  = pcsrc;
    i_nextpc = npc;
    step();
    i_ready  = 1'b0;
    i_pcsrc  = 1'($urandom_range(0, 1));
    i_nextpc = $urandom;
    exp_pc     = pcsrc ? npc : exp_pc + 32'd4;
    exp_icount = exp_icount + 32'd1;
    check("retire_valid", 32'(o_valid), 32'd0);
    check("icount", o_icount, exp_icount);
    check("next_pc", o_pc, exp_pc);
    check("next_addr", o_imem_addr, exp_pc);
    check("next_req", 32'(o_imem_req), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1; i_imem_ack = 1'b0; i_imem_data = '0;
    i_ready = 1'b0; i_pcsrc = 1'b0; i_nextpc = '0;
    exp_pc = RST_PC; exp_instr = '0; exp_icount = '0;
    repeat (3) step();
    check("rst_req", 32'(o_imem_req), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_pc", o_pc, RST_PC);
    check("rst_instr", o_instr, 32'h0);
    check("rst_timeout", 32'(o_timeout), 32'd0);
    check("rst_icount", o_icount, 32'd0);
    i_rst = 1'b0;
    check("idle_req", 32'(o_imem_req), 32'd0);
    step();
    check("first_req", 32'(o_imem_req), 32'd1);

    // First fetch, zero-wait ack.
    fetch(0, 32'h2008_0005);
    // Three sequential retires: 0 -> 4 -> 8 -> C.
    for (int i = 0; i < 3; i++) begin
      retire(1'b0, $urandom);
      fetch(0, $urandom);
    end
    check("icount_3", o_icount, 32'd3);
    check("pc_C", o_pc, 32'h0000_000C);
    retire(1'b0, $urandom);
    fetch(0, $urandom);
    retire(1'b1, 32'h40);
    fetch(0, $urandom);
    hold(5);

    // Randomized transactions.
    for (int i = 0; i < 40; i++) begin
      retire(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC);
      fetch($urandom_range(0, TMO - 1), $urandom);
      hold($urandom_range(0, 4));
    end

    // Sequential wrap at the top of the address space.
    retire(1'b1, 32'hFFFF_FFFC);
    fetch(0, $urandom);
    retire(1'b0, $urandom);
    check("wrap_pc", o_pc, 32'h0);
    fetch(1, $urandom);

`ifdef FETCH_ALIGN_CHECK_EN
    i_ready = 1'b1; i_pcsrc = 1'b1; i_nextpc = 32'h42;
    step();
    i_ready = 1'b0; i_pcsrc = 1'b0;
    check("mis_flag", 32'(o_misalign), 32'd1);
    check("mis_req", 32'(o_imem_req), 32'd0);
    check("mis_valid", 32'(o_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("mis_noreq", 32'(o_imem_req), 32'd0);
      check("mis_sticky", 32'(o_misalign), 32'd1);
    end
    i_rst = 1'b1;
    step();
    check("mis_clear", 32'(o_misalign), 32'd0);
    check("mis_rst_pc", o_pc, RST_PC);
    i_rst = 1'b0;
    exp_pc = RST_PC; exp_icount = '0;
    step();
`else
    retire(1'b1, 32'h42);
`endif

    // Withhold ack: ERR after TMO ack-less REQ cycles.
    wait_req();
    check("tmo_addr", o_imem_addr, exp_pc);
    for (int unsigned k = 0; k < TMO - 1; k++) begin
      step();
      check("tmo_req_held", 32'(o_imem_req), 32'd1);
      check("tmo_flag_low", 32'(o_timeout), 32'd0);
    end
    step();
    check("tmo_flag", 32'(o_timeout), 32'd1);
    check("tmo_req", 32'(o_imem_req), 32'd0);
    i_imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("err_req", 32'(o_imem_req), 32'd0);
      check("err_valid", 32'(o_valid), 32'd0);
      check("err_sticky", 32'(o_timeout), 32'd1);
    end
    i_imem_ack = 1'b0;

    // Reset out of ERR, then asynchronous reset in the middle of a request.
    i_rst = 1'b1;
    step();
    check("err_rst_flag", 32'(o_timeout), 32'd0);
    i_rst = 1'b0;
    step();
    check("rereq", 32'(o_imem_req), 32'd1);
    #2;
    i_rst = 1'b1;
    #1;
    check("async_req_drop", 32'(o_imem_req), 32'd0);
    i_imem_ack = 1'b1;
    step();
    i_rst = 1'b0;
    step();
    i_imem_ack = 1'b0;
    check("late_ack_valid", 32'(o_valid), 32'd0);
    check("late_ack_req", 32'(o_imem_req), 32'd1);
    exp_pc = RST_PC; exp_icount = '0;
    fetch(0, 32'h2008_0005);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first instruction fetched after reset.
REQ-002 Parameter TIMEOUT, default 16, i_imem_ack wait limit in cycles; legal range 2..255.
REQ-003 i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 i_rst  in  1  asynchronous, active-high reset.
REQ-005 o_imem_req  out  1  instruction memory read request; level-held until acknowledged.
REQ-006 o_imem_addr  out  32  instruction memory read address; equals o_pc.
REQ-007 i_imem_ack  in  1  memory acknowledge; i_imem_data is valid in the same cycle.
REQ-008 i_imem_data  in  32  instruction word.
REQ-009 o_instr  out  32  latched instruction presented to decode/execute.
REQ-010 o_pc  out  32  address of o_instr, and of any pending request.
REQ-011 o_pc_plus4  out  32  o_pc + 4, the base for branch-target computation downstream.
REQ-012 o_valid  out  1  o_instr/o_pc hold a valid instruction.
REQ-013 i_ready  in  1  consumer retires the presented instruction this cycle.
REQ-014 i_pcsrc  in  1  from execute: 1 = take i_nextpc; 0 = sequential.
REQ-015 i_nextpc  in  32  from execute: branch/jump target.
REQ-016 o_timeout  out  1  sticky flag: memory did not acknowledge within TIMEOUT cycles.
REQ-017 o_icount  out  32  number of retired instructions.

Function
REQ-018 States: IDLE, REQ, HOLD, ERR.
REQ-019 IDLE lasts exactly one cycle after reset, then unconditionally transitions to REQ.
REQ-020 REQ drives o_imem_req=1; on i_imem_ack, latch i_imem_data into o_instr, set o_valid=1, go to HOLD; ack in the first REQ cycle is legal.
REQ-021 i_imem_ack outside REQ is ignored, with no state change.
REQ-022 HOLD drives o_imem_req=0; o_instr, o_pc and o_valid remain stable until i_ready=1.
REQ-023 HOLD with i_ready=1: o_valid clears next cycle, o_icount increments, FSM goes to REQ.
REQ-024 In that same HOLD/i_ready cycle, o_pc loads i_nextpc if i_pcsrc=1, else o_pc+4.
REQ-025 i_pcsrc and i_nextpc are sampled only in a HOLD cycle with i_ready=1 and are ignored otherwise.
REQ-026 All address arithmetic is 32-bit modulo 2^32: o_pc=32'hFFFF_FFFC sequential wraps to 32'h0000_0000.
REQ-027 i_ready in a cycle with o_valid=0 is ignored.
REQ-028 Fetch latency: o_valid rises the cycle after the acknowledged REQ cycle; minimum retire-to-next-valid is 2 cycles.
REQ-029 The REQ wait counter clears on entry to REQ and increments each REQ cycle without ack.
REQ-030 When the wait counter reaches TIMEOUT, the FSM goes to ERR and sets o_timeout=1.
REQ-031 ERR is terminal until reset: o_imem_req=0, o_valid=0.
REQ-032 o_icount wraps from 32'hFFFF_FFFF to 0.

Reset
REQ-033 Reset values: state=IDLE, o_pc=RESET_PC, o_instr=32'h0000_0000 (MIPS nop), o_valid=0, o_imem_req=0, o_timeout=0, o_icount=0, wait counter=0.
REQ-034 Reset asserted mid-request drops o_imem_req immediately (asynchronously); a late ack after reset is ignored per REQ-021.

Configuration
REQ-035 Macro FETCH_ALIGN_CHECK_EN, when defined, adds output o_misalign (1 bit).
REQ-036 With FETCH_ALIGN_CHECK_EN defined: a taken redirect with i_nextpc[1:0]!=0 sets o_misalign=1 (sticky until reset) and sends the FSM to ERR.
REQ-037 With FETCH_ALIGN_CHECK_EN defined: no request is issued to the misaligned address.
REQ-038 Without FETCH_ALIGN_CHECK_EN: no o_misalign port, and i_nextpc is loaded unchecked.

Verification
REQ-039 Reset release, ack on first REQ cycle with data 32'h2008_0005 -> o_imem_addr=0; o_valid=1 with o_instr=32'h2008_0005 one cycle later; o_pc_plus4=4.
REQ-040 Three retires with i_pcsrc=0 and zero-wait acks -> o_pc sequence 0,4,8,C; o_icount=3.
REQ-041 Retire at o_pc=32'h10 with i_pcsrc=1, i_nextpc=32'h40 -> next o_imem_addr=32'h40.
REQ-042 Hold i_ready=0 for 5 cycles in HOLD -> o_instr/o_pc unchanged; o_imem_req=0 throughout.
REQ-043 Withhold ack in REQ -> o_timeout=1 and o_imem_req=0 after 16 cycles; only reset clears it.
REQ-044 FETCH_ALIGN_CHECK_EN defined, redirect to 32'h42 -> o_misalign=1, no request to 32'h42; reset clears it and o_pc returns to RESET_PC.
